// File: rtl/carrier_pwm.sv
// Programmable-duty carrier generator: HIGH/LOW phase lengths in prescaled ticks,
// period-boundary double buffering. Define CARRIER_PWM_GRACEFUL_STOP_EN to finish the period on en=0.
module carrier_pwm #(
  parameter int TIMER_WIDTH    = 11,
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      sys_rst_n,
  input  logic                      en,
  input  logic [TIMER_WIDTH-1:0]    high_duration,
  input  logic [TIMER_WIDTH-1:0]    low_duration,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      idle_level,
  output logic                      out,
  output logic                      period_tick,
  output logic                      busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  localparam logic [TIMER_WIDTH-1:0]    CNT_ZERO = {TIMER_WIDTH{1'b0}};
  localparam logic [TIMER_WIDTH-1:0]    CNT_ONE  = {{(TIMER_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_WIDTH-1:0] PRE_ZERO = {PRESCALE_WIDTH{1'b0}};
  localparam logic [PRESCALE_WIDTH-1:0] PRE_ONE  = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};

`ifdef CARRIER_PWM_GRACEFUL_STOP_EN
  localparam logic GRACEFUL = 1'b1;
`else
  localparam logic GRACEFUL = 1'b0;
`endif

  logic [1:0]                state_q, state_d;
  logic [TIMER_WIDTH-1:0]    cnt_q, cnt_d;
  logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
  logic [TIMER_WIDTH-1:0]    act_high_q, act_high_d;
  logic [TIMER_WIDTH-1:0]    act_low_q, act_low_d;
  logic [PRESCALE_WIDTH-1:0] act_pre_q, act_pre_d;
  logic                      out_q, out_d;
  logic                      tick_q, tick_d;
  logic                      busy_q, busy_d;
  logic                      pre_tick_s;
  logic                      start_s;
  logic                      stop_s;

  // Next-state logic: phase sequencing, prescaler and shadow-register capture
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pre_d      = pre_q;
    act_high_d = act_high_q;
    act_low_d  = act_low_q;
    act_pre_d  = act_pre_q;
    out_d      = out_q;
    tick_d     = 1'b0;
    busy_d     = busy_q;
    start_s    = 1'b0;
    stop_s     = 1'b0;
    pre_tick_s = (pre_q == PRE_ZERO);

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          start_s = 1'b1;
        end else begin
          stop_s = 1'b1;
        end
      end
      ST_HIGH: begin
        if (!en && !GRACEFUL) begin
          stop_s = 1'b1;
        end else if (pre_tick_s) begin
          pre_d = act_pre_q;
          if (cnt_q == CNT_ZERO) begin
            state_d = ST_LOW;
            out_d   = 1'b0;
            cnt_d   = act_low_q;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end else begin
          pre_d = pre_q - PRE_ONE;
        end
      end
      ST_LOW: begin
        if (!en && !GRACEFUL) begin
          stop_s = 1'b1;
        end else if (pre_tick_s) begin
          pre_d = act_pre_q;
          if (cnt_q == CNT_ZERO) begin
            // en is re-sampled here so a graceful stop can still be cancelled
            if (en) begin
              start_s = 1'b1;
            end else begin
              stop_s = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end else begin
          pre_d = pre_q - PRE_ONE;
        end
      end
      default: begin
        stop_s = 1'b1;
      end
    endcase

    if (start_s) begin
      act_high_d = high_duration;
      act_low_d  = low_duration;
      act_pre_d  = prescale;
      cnt_d      = high_duration;
      pre_d      = prescale;
      state_d    = ST_HIGH;
      out_d      = 1'b1;
      tick_d     = 1'b1;
      busy_d     = 1'b1;
    end else if (stop_s) begin
      state_d = ST_IDLE;
      out_d   = idle_level;
      busy_d  = 1'b0;
    end else begin
      busy_d = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= CNT_ZERO;
      pre_q      <= PRE_ZERO;
      act_high_q <= CNT_ZERO;
      act_low_q  <= CNT_ZERO;
      act_pre_q  <= PRE_ZERO;
      out_q      <= 1'b0;
      tick_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pre_q      <= pre_d;
      act_high_q <= act_high_d;
      act_low_q  <= act_low_d;
      act_pre_q  <= act_pre_d;
      out_q      <= out_d;
      tick_q     <= tick_d;
      busy_q     <= busy_d;
    end
  end

  assign out         = out_q;
  assign period_tick = tick_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_carrier_pwm.sv
// Scoreboard bench for carrier_pwm: stimulus queues per-cycle {out,period_tick,busy}
// expectations; a negedge monitor pops and compares them.
module tb_carrier_pwm;

  localparam int TW = 11;
  localparam int PW = 4;

  logic          clk;
  logic          sys_rst_n;
  logic          en;
  logic [TW-1:0] high_duration;
  logic [TW-1:0] low_duration;
  logic [PW-1:0] prescale;
  logic          idle_level;
  logic          out;
  logic          period_tick;
  logic          busy;

  logic [2:0] exp_q[$];
  int n_cmp;
  int n_err;
  int n_cyc;

  carrier_pwm #(.TIMER_WIDTH(TW), .PRESCALE_WIDTH(PW)) dut (
    .clk          (clk),
    .sys_rst_n    (sys_rst_n),
    .en           (en),
    .high_duration(high_duration),
    .low_duration (low_duration),
    .prescale     (prescale),
    .idle_level   (idle_level),
    .out          (out),
    .period_tick  (period_tick),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: one expectation per sampled cycle while the scoreboard holds entries
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [2:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      if ({out, period_tick, busy} !== e) begin
        n_err++;
        $display("FAIL cycle%0d out/tick/busy: got %b%b%b expected %b", n_cyc, out, period_tick, busy, e);
      end
      n_cyc++;
    end
  end

  task automatic push(input logic o, input logic t, input logic b, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({o, t, b});
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; n_cyc = 0;
    sys_rst_n = 1'b0; en = 1'b0; idle_level = 1'b0;
    high_duration = 11'd0; low_duration = 11'd0; prescale = 4'd0;
    #3;
    check("rst_out", out, 1'b0);
    check("rst_tick", period_tick, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk); #2;

    // Async reset mid-HIGH: prescale=2, high=5
    sys_rst_n = 1'b1;
    en = 1'b1; prescale = 4'd2; high_duration = 11'd5; low_duration = 11'd5;
    push(1'b0, 1'b0, 1'b0, 1);
    push(1'b1, 1'b1, 1'b1, 1);
    push(1'b1, 1'b0, 1'b1, 3);
    run(5);
    #1 sys_rst_n = 1'b0;
    #1;
    check("midrst_out", out, 1'b0);
    check("midrst_tick", period_tick, 1'b0);
    check("midrst_busy", busy, 1'b0);
    en = 1'b0;
    @(posedge clk); #2;
    sys_rst_n = 1'b1;

    // prescale=0, high=low=3: 4 high / 4 low, tick every 8
    en = 1'b1; prescale = 4'd0; high_duration = 11'd3; low_duration = 11'd3;
    push(1'b0, 1'b0, 1'b0, 1);
    for (int p = 0; p < 2; p++) begin
      push(1'b1, 1'b1, 1'b1, 1);
      push(1'b1, 1'b0, 1'b1, 3);
      push(1'b0, 1'b0, 1'b1, 4);
    end
    run(17);
    // en dropped one clock into HIGH
    en = 1'b0;
`ifdef CARRIER_PWM_GRACEFUL_STOP_EN
    push(1'b1, 1'b1, 1'b1, 1);
    push(1'b1, 1'b0, 1'b1, 3);
    push(1'b0, 1'b0, 1'b1, 4);
    push(1'b0, 1'b0, 1'b0, 2);
    run(10);
`else
    push(1'b1, 1'b1, 1'b1, 1);
    push(1'b0, 1'b0, 1'b0, 2);
    run(3);
`endif

    // prescale=1, high=2, low=0: 6 high / 2 low
    en = 1'b1; prescale = 4'd1; high_duration = 11'd2; low_duration = 11'd0;
    push(1'b0, 1'b0, 1'b0, 1);
    for (int p = 0; p < 2; p++) begin
      push(1'b1, 1'b1, 1'b1, 1);
      push(1'b1, 1'b0, 1'b1, 5);
      push(1'b0, 1'b0, 1'b1, 2);
    end
    run(17);

    // Mid-period input change: current 6/2 period unaffected, next uses pre=0 high=3 low=3
    prescale = 4'd0; high_duration = 11'd3; low_duration = 11'd3;
    push(1'b1, 1'b1, 1'b1, 1);
    push(1'b1, 1'b0, 1'b1, 5);
    push(1'b0, 1'b0, 1'b1, 2);
    push(1'b1, 1'b1, 1'b1, 1);
    push(1'b1, 1'b0, 1'b1, 1);
    run(10);
    // high 3->1 midway through HIGH: this HIGH still 4 clocks, next HIGH 2 clocks
    high_duration = 11'd1;
    push(1'b1, 1'b0, 1'b1, 2);
    push(1'b0, 1'b0, 1'b1, 4);
    push(1'b1, 1'b1, 1'b1, 1);
    push(1'b1, 1'b0, 1'b1, 1);
    push(1'b0, 1'b0, 1'b1, 4);
    run(12);

    // idle_level=1, en dropped during LOW
    idle_level = 1'b1;
    push(1'b1, 1'b1, 1'b1, 1);
    push(1'b1, 1'b0, 1'b1, 1);
    push(1'b0, 1'b0, 1'b1, 2);
    run(4);
    en = 1'b0;
`ifdef CARRIER_PWM_GRACEFUL_STOP_EN
    push(1'b0, 1'b0, 1'b1, 2);
    push(1'b1, 1'b0, 1'b0, 2);
    run(4);
`else
    push(1'b0, 1'b0, 1'b1, 1);
    push(1'b1, 1'b0, 1'b0, 3);
    run(4);
`endif

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/carrier_pwm.md
Name: carrier_pwm

Overview:
- Parametrised successor to the fixed 50% carrier generator.
- Produces a carrier with independently programmable high and low phase lengths, a shared clock prescaler, and a programmable idle level.
- Timing changes are double-buffered and take effect only at period boundaries, so the output never glitches.
- Sits between the pulse-transmitter register block and the output modulator, which ANDs it with the pulse envelope.

Parameters:
- TIMER_WIDTH, 11, width of high_duration, low_duration and the phase counter.
- PRESCALE_WIDTH, 4, width of prescale and the prescaler counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- sys_rst_n  input  1  asynchronous active-low reset; one clock, asynchronous assert, active-low.
- en  input  1  run enable; level-sensitive.
- high_duration  input  TIMER_WIDTH  high phase length minus 1, in prescaled ticks.
- low_duration  input  TIMER_WIDTH  low phase length minus 1, in prescaled ticks.
- prescale  input  PRESCALE_WIDTH  tick divider minus 1; a tick occurs every prescale+1 clocks.
- idle_level  input  1  value driven on out while idle.
- out  output  1  registered carrier output.
- period_tick  output  1  registered one-clock pulse on the cycle out enters HIGH phase.
- busy  output  1  registered; 1 whenever state is not IDLE.

Behaviour:
- Reset (asynchronous, sys_rst_n=0):
  - state=IDLE; out=0, period_tick=0, busy=0.
  - All counters and active (shadow) registers cleared to 0.
- States: IDLE, HIGH, LOW.
- Active registers: act_high, act_low, act_pre.
  - Loaded from the inputs on IDLE->HIGH and on every LOW->HIGH transition.
  - Inputs changed mid-period have no effect until the next period start.
- IDLE:
  - out <= idle_level every cycle; busy=0.
  - If en=1 at an edge: load active registers; phase counter <= high_duration; prescaler <= prescale; state <= HIGH; out <= 1; period_tick <= 1; busy <= 1.
  - Latency: out is 1 in the cycle after the first edge that samples en=1.
- Prescaler:
  - Counts down from act_pre.
  - At 0 it generates an internal tick and reloads act_pre.
  - act_pre=0 gives a tick on every clock.
- HIGH / LOW:
  - On a tick with phase counter != 0: decrement the counter.
  - On a tick with counter == 0:
    - HIGH -> LOW: out <= 0; counter <= act_low.
    - LOW -> HIGH: reload active registers from inputs; counter <= new high value; out <= 1; period_tick <= 1.
  - The prescaler reloads with the new act_pre at the period boundary.
- Phase lengths:
  - HIGH lasts (act_high+1)*(act_pre+1) clocks.
  - LOW lasts (act_low+1)*(act_pre+1) clocks.
  - All-zero inputs give a 2-clock period, 50% duty.
- period_tick is 0 on every cycle except the one following a HIGH entry.
- en deassert (default build):
  - At the first edge sampling en=0 from HIGH or LOW: state <= IDLE; out <= idle_level; busy <= 0.
  - Counters are abandoned; no period_tick is generated.
- Simultaneous events:
  - en falling on the same edge as a phase end: the en=0 response takes priority.
  - Input change on the same edge as LOW->HIGH: the new values are captured.
- Width rules:
  - All counters are unsigned, with no wrap beyond the loaded value.
  - Maximum period is 2*(2^TIMER_WIDTH)*(2^PRESCALE_WIDTH) clocks.
- Reset mid-operation: immediate return to reset values, independent of clk.

Optional Feature:
- Macro: CARRIER_PWM_GRACEFUL_STOP_EN.
- Defined:
  - en=0 during HIGH or LOW does not abort; the current period completes through the end of LOW, then the block enters IDLE.
  - No new period_tick is issued during the stop.
  - busy stays 1 until IDLE.
  - en reasserted before the LOW phase ends cancels the stop; the next period starts normally.
- Undefined: immediate abort, as in Behaviour.

Test Plan:
- Reset mid-HIGH with prescale=2 and high_duration=5 -> out, period_tick and busy are 0 immediately, with no clock edge required.
- en=1, prescale=0, high=3, low=3, idle_level=0 -> out 4 clocks high, 4 clocks low, repeating; period_tick every 8 clocks; busy=1.
- prescale=1, high=2, low=0 -> high 6 clocks, low 2 clocks; period_tick period 8 clocks.
- Change high 3->1 midway through a HIGH phase -> current HIGH still lasts 4 clocks; the following HIGH lasts 2 clocks.
- idle_level=1, toggle en 1->0 during LOW -> out=1 one cycle after en=0 sampled; busy=0; no period_tick.
- With CARRIER_PWM_GRACEFUL_STOP_EN, high=low=3, en dropped on the 2nd clock of HIGH -> out finishes 4 high and 4 low, then goes to idle_level; no period_tick after the stop.
